// File: rtl/vmu_mem_port.sv
// vmu_mem_port: VMU-to-dcache request FIFO with load credit accounting and a registered response stage.
module vmu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int MICROOP_WIDTH = 5,
  parameter int REQ_DATA_WIDTH = 256,
  parameter int VECTOR_LANES = 8,
  parameter int DEPTH = 4,
  parameter int MAX_LD_OUT = 8,
  localparam int TW = $clog2(VECTOR_LANES) + 1,
  localparam int SW = $clog2(REQ_DATA_WIDTH / 8) + 1,
  localparam int CW = $clog2(MAX_LD_OUT) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [MICROOP_WIDTH-1:0]  req_microop_i,
  input  logic [SW-1:0]             req_size_i,
  input  logic [TW-1:0]             req_ticket_i,
  input  logic [REQ_DATA_WIDTH-1:0] req_data_i,
  output logic                      req_ready_o,
  output logic                      dc_req_valid_o,
  output logic [ADDR_WIDTH-1:0]     dc_req_addr_o,
  output logic [MICROOP_WIDTH-1:0]  dc_req_microop_o,
  output logic [SW-1:0]             dc_req_size_o,
  output logic [TW-1:0]             dc_req_ticket_o,
  output logic [REQ_DATA_WIDTH-1:0] dc_req_data_o,
  input  logic                      dc_req_ready_i,
  input  logic                      dc_resp_valid_i,
  input  logic [TW-1:0]             dc_resp_ticket_i,
  input  logic [SW-1:0]             dc_resp_size_i,
  input  logic [REQ_DATA_WIDTH-1:0] dc_resp_data_i,
  output logic                      resp_valid_o,
  output logic [TW-1:0]             resp_ticket_o,
  output logic [SW-1:0]             resp_size_o,
  output logic [REQ_DATA_WIDTH-1:0] resp_data_o,
  output logic [CW-1:0]             ld_outstanding_o,
  output logic                      idle_o,
  output logic                      err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_WIDTH + MICROOP_WIDTH + SW + TW + REQ_DATA_WIDTH;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [CW-1:0] ld_queued;
  logic push, pop, push_ld, pop_ld, resp_dec;
  // Ready is purely registered so the VMU grant can depend on it combinationally.
  assign req_ready_o = (count < (PW+1)'(DEPTH)) &&
                       (({1'b0, ld_queued} + {1'b0, ld_outstanding_o}) < (CW+1)'(MAX_LD_OUT));
  assign dc_req_valid_o = count != '0;
  assign {dc_req_addr_o, dc_req_microop_o, dc_req_size_o, dc_req_ticket_o, dc_req_data_o} = mem[rd_ptr];
  assign push = req_valid_i & req_ready_o;
  assign pop = dc_req_valid_o & dc_req_ready_i;
  assign push_ld = push & (req_microop_i == '0);
  assign pop_ld = pop & (dc_req_microop_o == '0);
  assign resp_dec = dc_resp_valid_i & (ld_outstanding_o != '0);
  assign idle_o = (count == '0) & (ld_outstanding_o == '0);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_addr_i, req_microop_i, req_size_i, req_ticket_i, req_data_i};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ld_queued <= '0;
      ld_outstanding_o <= '0;
      err_o <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_ticket_o <= '0;
      resp_size_o <= '0;
      resp_data_o <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      ld_queued <= ld_queued + CW'(push_ld) - CW'(pop_ld);
      ld_outstanding_o <= ld_outstanding_o + CW'(pop_ld) - CW'(resp_dec);
      err_o <= err_o | (dc_resp_valid_i & (ld_outstanding_o == '0));
      resp_valid_o <= dc_resp_valid_i;
      resp_ticket_o <= dc_resp_ticket_i;
      resp_size_o <= dc_resp_size_i;
      resp_data_o <= dc_resp_data_i;
    end
endmodule

// File: tb/tb_vmu_mem_port.sv
// tb_vmu_mem_port: directed vector table plus hand sequences for fill, credit, spurious response and reset.
module tb_vmu_mem_port;
  logic clk = 0, rst_n = 0;
  logic req_valid_i = 0, dc_req_ready_i = 0, dc_resp_valid_i = 0;
  logic [31:0] req_addr_i = 0;
  logic [4:0] req_microop_i = 0;
  logic [5:0] req_size_i = 6'd32, dc_resp_size_i = 0;
  logic [3:0] req_ticket_i = 0, dc_resp_ticket_i = 0;
  logic [255:0] req_data_i = 0, dc_resp_data_i = 0;
  logic req_ready_o, dc_req_valid_o, resp_valid_o, idle_o, err_o;
  logic [31:0] dc_req_addr_o;
  logic [4:0] dc_req_microop_o;
  logic [5:0] dc_req_size_o, resp_size_o;
  logic [3:0] dc_req_ticket_o, resp_ticket_o, ld_outstanding_o;
  logic [255:0] dc_req_data_o, resp_data_o;
  int errors = 0, checks = 0;

  vmu_mem_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_microop_i(req_microop_i),
    .req_size_i(req_size_i), .req_ticket_i(req_ticket_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .dc_req_valid_o(dc_req_valid_o), .dc_req_addr_o(dc_req_addr_o), .dc_req_microop_o(dc_req_microop_o),
    .dc_req_size_o(dc_req_size_o), .dc_req_ticket_o(dc_req_ticket_o), .dc_req_data_o(dc_req_data_o),
    .dc_req_ready_i(dc_req_ready_i),
    .dc_resp_valid_i(dc_resp_valid_i), .dc_resp_ticket_i(dc_resp_ticket_i),
    .dc_resp_size_i(dc_resp_size_i), .dc_resp_data_i(dc_resp_data_i),
    .resp_valid_o(resp_valid_o), .resp_ticket_o(resp_ticket_o), .resp_size_o(resp_size_o),
    .resp_data_o(resp_data_o), .ld_outstanding_o(ld_outstanding_o), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [31:0] a; logic [4:0] mo; logic [3:0] t; logic rdy; logic rv; logic [3:0] rt;
    logic edv; logic [31:0] ea; logic [3:0] et; logic erdy; logic [3:0] eo; logic erv; logic [3:0] ert; logic eidle;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid_i = 0; req_addr_i = 0; req_microop_i = 0; req_ticket_i = 0; req_data_i = 0;
    dc_req_ready_i = 0; dc_resp_valid_i = 0; dc_resp_ticket_i = 0; dc_resp_size_i = 0; dc_resp_data_i = 0;
  endtask

  initial begin
    tbl[0]  = '{0, 32'h0,    0, 0, 0, 0, 0,  0, 32'h0,    0, 1, 0, 0, 0, 1};
    tbl[1]  = '{1, 32'h1000, 0, 3, 1, 0, 0,  1, 32'h1000, 3, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 32'h0,    0, 0, 1, 0, 0,  0, 32'h0,    0, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 32'h0,    0, 0, 1, 1, 3,  0, 32'h0,    0, 1, 0, 1, 3, 1};
    tbl[4]  = '{0, 32'h0,    0, 0, 0, 0, 0,  0, 32'h0,    0, 1, 0, 0, 0, 1};
    tbl[5]  = '{1, 32'h2000, 0, 1, 1, 0, 0,  1, 32'h2000, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 32'h3000, 0, 2, 1, 0, 0,  1, 32'h3000, 2, 1, 1, 0, 0, 0};
    tbl[7]  = '{1, 32'h4000, 1, 0, 1, 0, 0,  1, 32'h4000, 0, 1, 2, 0, 0, 0};
    tbl[8]  = '{1, 32'h5000, 0, 6, 1, 0, 0,  1, 32'h5000, 6, 1, 2, 0, 0, 0};
    tbl[9]  = '{0, 32'h0,    0, 0, 1, 1, 1,  0, 32'h0,    0, 1, 2, 1, 1, 0};
    tbl[10] = '{0, 32'h0,    0, 0, 0, 1, 2,  0, 32'h0,    0, 1, 1, 1, 2, 0};
    tbl[11] = '{0, 32'h0,    0, 0, 0, 1, 6,  0, 32'h0,    0, 1, 0, 1, 6, 1};
    tbl[12] = '{0, 32'h0,    0, 0, 0, 0, 0,  0, 32'h0,    0, 1, 0, 0, 0, 1};

    #2;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_dc_valid", dc_req_valid_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_err", err_o, 0);
    chk("rst_out", ld_outstanding_o, 0);
    tick;
    rst_n = 1;
    tick;

    for (int i = 0; i < 13; i++) begin
      req_valid_i = tbl[i].v; req_addr_i = tbl[i].a; req_microop_i = tbl[i].mo; req_ticket_i = tbl[i].t;
      dc_req_ready_i = tbl[i].rdy; dc_resp_valid_i = tbl[i].rv; dc_resp_ticket_i = tbl[i].rt;
      dc_resp_size_i = {2'b0, tbl[i].rt};
      tick;
      chk($sformatf("v%0d_dc_valid", i), dc_req_valid_o, tbl[i].edv);
      if (tbl[i].edv) begin
        chk($sformatf("v%0d_dc_addr", i), dc_req_addr_o, tbl[i].ea);
        chk($sformatf("v%0d_dc_ticket", i), dc_req_ticket_o, tbl[i].et);
      end
      chk($sformatf("v%0d_ready", i), req_ready_o, tbl[i].erdy);
      chk($sformatf("v%0d_out", i), ld_outstanding_o, tbl[i].eo);
      chk($sformatf("v%0d_resp_valid", i), resp_valid_o, tbl[i].erv);
      if (tbl[i].erv) begin
        chk($sformatf("v%0d_resp_ticket", i), resp_ticket_o, tbl[i].ert);
        chk($sformatf("v%0d_resp_size", i), resp_size_o, {2'b0, tbl[i].ert});
      end
      chk($sformatf("v%0d_idle", i), idle_o, tbl[i].eidle);
    end
    chk("table_err", err_o, 0);
    idle_inputs;

    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1; req_microop_i = 1; req_addr_i = 32'hA0 + i; req_ticket_i = 4'(i);
      req_data_i = {8{32'hC0DE0000 + i}};
      tick;
      chk($sformatf("fill%0d_ready", i), req_ready_o, i < 3);
      chk($sformatf("fill%0d_head", i), dc_req_addr_o, 32'hA0);
    end
    req_addr_i = 32'hDEAD;
    tick;
    req_valid_i = 0;
    chk("full_head_stable", dc_req_addr_o, 32'hA0);
    dc_req_ready_i = 1;
    chk("full_no_bypass", req_ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), dc_req_valid_o, 1);
      chk($sformatf("drain%0d_addr", i), dc_req_addr_o, 32'hA0 + i);
      chk($sformatf("drain%0d_data", i), dc_req_data_o, {8{32'hC0DE0000 + i}});
      tick;
      chk($sformatf("drain%0d_out", i), ld_outstanding_o, 0);
    end
    chk("drain_empty", dc_req_valid_o, 0);
    chk("drain_idle", idle_o, 1);
    idle_inputs;

    dc_req_ready_i = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("credit%0d_ready", i), req_ready_o, 1);
      req_valid_i = 1; req_addr_i = 32'h8000 + 32'(i); req_ticket_i = 4'(i);
      tick;
    end
    req_valid_i = 0;
    chk("credit_ready_q", req_ready_o, 0);
    tick;
    chk("credit_ready", req_ready_o, 0);
    chk("credit_out", ld_outstanding_o, 8);
    dc_resp_valid_i = 1; dc_resp_ticket_i = 0;
    tick;
    dc_resp_valid_i = 0;
    chk("credit_release", req_ready_o, 1);
    chk("credit_out7", ld_outstanding_o, 7);
    for (int i = 1; i < 8; i++) begin
      dc_resp_valid_i = 1; dc_resp_ticket_i = 4'(i);
      tick;
    end
    dc_resp_valid_i = 0;
    chk("credit_drain_out", ld_outstanding_o, 0);
    chk("credit_drain_err", err_o, 0);
    tick;
    chk("credit_drain_idle", idle_o, 1);
    idle_inputs;

    dc_resp_valid_i = 1; dc_resp_ticket_i = 9; dc_resp_size_i = 6'd32; dc_resp_data_i = {4{64'h0123456789ABCDEF}};
    tick;
    dc_resp_valid_i = 0;
    chk("spur_resp_valid", resp_valid_o, 1);
    chk("spur_ticket", resp_ticket_o, 9);
    chk("spur_size", resp_size_o, 32);
    chk("spur_data", resp_data_o, {4{64'h0123456789ABCDEF}});
    chk("spur_err", err_o, 1);
    chk("spur_out", ld_outstanding_o, 0);
    tick;
    tick;
    chk("spur_pulse", resp_valid_o, 0);
    chk("spur_sticky", err_o, 1);

    dc_req_ready_i = 1; req_valid_i = 1; req_addr_i = 32'hF000; req_ticket_i = 2;
    tick;
    req_valid_i = 0;
    tick;
    chk("pre_rst_out", ld_outstanding_o, 1);
    req_valid_i = 1; dc_req_ready_i = 0;
    tick;
    req_valid_i = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_out", ld_outstanding_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_dc_valid", dc_req_valid_o, 0);
    chk("arst_idle", idle_o, 1);
    chk("arst_ready", req_ready_o, 1);
    tick;
    rst_n = 1;
    tick;
    dc_resp_valid_i = 1; dc_resp_ticket_i = 2;
    tick;
    dc_resp_valid_i = 0;
    chk("post_rst_resp_valid", resp_valid_o, 1);
    chk("post_rst_err", err_o, 1);
    chk("post_rst_out", ld_outstanding_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
